// File: rtl/sw_dispatch_pkg.sv
// Line and result-entry layout shared by the multi-channel dispatch data path.
// Line bit indices count from the first (most significant) bit of the DMA line.
package sw_dispatch_pkg;

    localparam int unsigned LINE_W  = 512;
    localparam int unsigned ID_LSB  = 0;
    localparam int unsigned ID_MSB  = 31;
    localparam int unsigned LEN_LSB = 32;
    localparam int unsigned LEN_MSB = 47;
    localparam int unsigned SEQ_LSB = 48;
    localparam int unsigned SEQ_MSB = 511;
    localparam int unsigned ID_W    = ID_MSB - ID_LSB + 1;
    localparam int unsigned SEQ_W   = SEQ_MSB - SEQ_LSB + 1;

    localparam int unsigned ENTRY_W       = 64;
    localparam int unsigned ENTRY_SCORE_W = 16;
    localparam int unsigned ENTRY_CH_W    = 8;
    localparam logic [7:0]  ENTRY_FLAG_VALID = 8'h01;

    typedef struct packed {
        logic [ID_W-1:0]          id;
        logic [ENTRY_SCORE_W-1:0] score;
        logic [ENTRY_CH_W-1:0]    ch;
        logic [7:0]               flag;
    } entry_t;

endpackage

// File: rtl/endian_swap.sv
// Byte-order reversal of a BYTES-wide field, bypassed when en_i is low.
module endian_swap #(
    parameter int unsigned BYTES = 2
) (
    input  logic               en_i,
    input  logic [8*BYTES-1:0] data_i,
    output logic [8*BYTES-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        if (en_i) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                data_o[8*b +: 8] = data_i[8*(int'(BYTES)-1-b) +: 8];
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer, and the
// pointer moves one past the grant whenever the grant is taken (adv_i).
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [N-1:0]                        req_i,
    input  logic                                adv_i,
    output logic [N-1:0]                        gnt_o,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx_o,
    output logic                                valid_o
);

    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int i = 0; i < int'(N); i++) begin
            cand = IdxW'((int'(ptr_q) + i) % int'(N));
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i && valid_o) begin
            ptr_d = (idx_o == IdxW'(N - 1)) ? '0 : idx_o + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sw_multi_dispatch.sv
// Dispatches DMA read lines round-robin to NUM_CH scoring channels and packs their
// scores into DMA write lines, with back-pressure and end-of-job flush.
module sw_multi_dispatch
    import sw_dispatch_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned RES_W   = 16,
    parameter int unsigned MAX_LEN = 232,
    parameter int unsigned ENTRIES = 8
) (
    input  logic                    ha_pclock,
    input  logic                    reset,
    input  logic                    little_endian,
    input  logic                    read_data_ready,
    input  logic [0:LINE_W-1]       read_data,
    output logic                    read_ack,
    output logic [NUM_CH-1:0]       ch_start,
    output logic [ID_W-1:0]         ch_id,
    output logic [LEN_W-1:0]        ch_len,
    output logic [SEQ_W-1:0]        ch_seq,
    input  logic [NUM_CH-1:0]       ch_done,
    input  logic [NUM_CH*RES_W-1:0] ch_score,
    input  logic                    write_data_ready,
    output logic [0:LINE_W-1]       write_data,
    output logic                    write_data_ack,
    input  logic                    flush,
    output logic                    flush_done,
    output logic                    idle,
    output logic [15:0]             drop_cnt,
    output logic [15:0]             clamp_cnt
);

    localparam int unsigned ChW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CntW = $clog2(ENTRIES + 1);

    logic [ID_W-1:0]  line_id;
    logic [15:0]      len_fix;
    logic [LEN_W-1:0] len, len_disp;
    logic [SEQ_W-1:0] line_seq;
    logic             len_zero, len_over, dispatch;

    logic [NUM_CH-1:0] free_gnt, pend_gnt;
    logic [ChW-1:0]    free_idx, pend_idx;
    logic              any_free, any_pend, pack;

    logic [NUM_CH-1:0] busy_q, busy_d, pend_q, pend_d;
    logic [ID_W-1:0]   id_q [NUM_CH];
    logic [ID_W-1:0]   id_d [NUM_CH];
    logic [RES_W-1:0]  score_q [NUM_CH];
    logic [RES_W-1:0]  score_d [NUM_CH];

    logic [NUM_CH-1:0] ch_start_q, ch_start_d;
    logic [ID_W-1:0]   ch_id_q, ch_id_d;
    logic [LEN_W-1:0]  ch_len_q, ch_len_d;
    logic [SEQ_W-1:0]  ch_seq_q, ch_seq_d;

    entry_t            buf_q [ENTRIES];
    entry_t            buf_d [ENTRIES];
    entry_t            pack_entry;
    logic [CntW-1:0]   count_q, count_d;
    logic [ENTRY_SCORE_W-1:0] score_sel, score_fix;

    logic        flushing_q, flushing_d, flush_done_q, flush_done_d;
    logic        flush_req, drained, full;
    logic [15:0] drop_q, drop_d, clamp_q, clamp_d;

    assign line_id  = read_data[ID_LSB:ID_MSB];
    assign line_seq = read_data[SEQ_LSB:SEQ_MSB];

    endian_swap #(.BYTES(2)) u_len_swap (
        .en_i   (little_endian),
        .data_i (read_data[LEN_LSB:LEN_MSB]),
        .data_o (len_fix)
    );

    assign len      = LEN_W'(len_fix);
    assign len_zero = (len == '0);
    assign len_over = (len > LEN_W'(MAX_LEN));
    assign len_disp = len_over ? LEN_W'(MAX_LEN) : len;

    rr_arbiter #(.N(NUM_CH)) u_free_arb (
        .clk_i   (ha_pclock),
        .rst_i   (reset),
        .req_i   (~busy_q),
        .adv_i   (dispatch),
        .gnt_o   (free_gnt),
        .idx_o   (free_idx),
        .valid_o (any_free)
    );

    rr_arbiter #(.N(NUM_CH)) u_pend_arb (
        .clk_i   (ha_pclock),
        .rst_i   (reset),
        .req_i   (pend_q),
        .adv_i   (pack),
        .gnt_o   (pend_gnt),
        .idx_o   (pend_idx),
        .valid_o (any_pend)
    );

    assign score_sel = ENTRY_SCORE_W'(score_q[pend_idx]);

    endian_swap #(.BYTES(2)) u_score_swap (
        .en_i   (little_endian),
        .data_i (score_sel),
        .data_o (score_fix)
    );

    always_comb begin
        pack_entry.id    = id_q[pend_idx];
        pack_entry.score = score_fix;
        pack_entry.ch    = ENTRY_CH_W'(pend_idx);
        pack_entry.flag  = ENTRY_FLAG_VALID;
    end

    assign read_ack = read_data_ready & any_free & ~flushing_q;
    assign dispatch = read_ack & ~len_zero;

    // A line accepted this cycle still counts as work in flight for the flush.
    always_comb begin
        flush_req      = flushing_q | flush;
        drained        = ~|busy_q & ~|pend_q & ~dispatch;
        full           = (count_q == CntW'(ENTRIES)) | (flush_req & drained & (count_q != '0));
        write_data_ack = write_data_ready & full;
        pack           = any_pend & ~full;
        flush_done_d   = flush_req & drained & ((count_q == '0) | write_data_ack);
        flushing_d     = flush_req & ~flush_done_d;
    end

    always_comb begin
        busy_d     = busy_q;
        pend_d     = pend_q;
        id_d       = id_q;
        score_d    = score_q;
        ch_start_d = '0;
        ch_id_d    = ch_id_q;
        ch_len_d   = ch_len_q;
        ch_seq_d   = ch_seq_q;
        buf_d      = buf_q;
        count_d    = count_q;
        drop_d     = drop_q;
        clamp_d    = clamp_q;

        if (dispatch) begin
            busy_d         = busy_d | free_gnt;
            id_d[free_idx] = line_id;
            ch_start_d     = free_gnt;
            ch_id_d        = line_id;
            ch_len_d       = len_disp;
            ch_seq_d       = line_seq;
            if (len_over && clamp_q != 16'hffff) begin
                clamp_d = clamp_q + 16'd1;
            end
        end
        if (read_ack && len_zero && drop_q != 16'hffff) begin
            drop_d = drop_q + 16'd1;
        end

        if (pack) begin
            busy_d = busy_d & ~pend_gnt;
            pend_d = pend_d & ~pend_gnt;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                if (count_q == CntW'(i)) begin
                    buf_d[i] = pack_entry;
                end
            end
            count_d = count_q + CntW'(1);
        end

        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (ch_done[k]) begin
                score_d[k] = ch_score[k*RES_W +: RES_W];
            end
        end
        pend_d = pend_d | ch_done;

        if (write_data_ack) begin
            buf_d   = '{default: '0};
            count_d = '0;
        end
    end

    always_comb begin
        write_data = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            write_data[ENTRY_W*i +: ENTRY_W] = buf_q[i];
        end
    end

    always_ff @(posedge ha_pclock) begin
        if (reset) begin
            busy_q       <= '0;
            pend_q       <= '0;
            id_q         <= '{default: '0};
            score_q      <= '{default: '0};
            ch_start_q   <= '0;
            ch_id_q      <= '0;
            ch_len_q     <= '0;
            ch_seq_q     <= '0;
            buf_q        <= '{default: '0};
            count_q      <= '0;
            flushing_q   <= 1'b0;
            flush_done_q <= 1'b0;
            drop_q       <= '0;
            clamp_q      <= '0;
        end else begin
            busy_q       <= busy_d;
            pend_q       <= pend_d;
            id_q         <= id_d;
            score_q      <= score_d;
            ch_start_q   <= ch_start_d;
            ch_id_q      <= ch_id_d;
            ch_len_q     <= ch_len_d;
            ch_seq_q     <= ch_seq_d;
            buf_q        <= buf_d;
            count_q      <= count_d;
            flushing_q   <= flushing_d;
            flush_done_q <= flush_done_d;
            drop_q       <= drop_d;
            clamp_q      <= clamp_d;
        end
    end

    assign ch_start   = ch_start_q;
    assign ch_id      = ch_id_q;
    assign ch_len     = ch_len_q;
    assign ch_seq     = ch_seq_q;
    assign flush_done = flush_done_q;
    assign drop_cnt   = drop_q;
    assign clamp_cnt  = clamp_q;
    assign idle       = ~|busy_q & ~|pend_q & (count_q == '0);

endmodule

// File: tb/tb_sw_multi_dispatch.sv
// Directed bench for sw_multi_dispatch: dispatch order, collection, back-pressure,
// drop/clamp, endianness and flush, with hand-computed expected values.
module tb_sw_multi_dispatch;

    logic          ha_pclock = 1'b0;
    logic          reset = 1'b1;
    logic          little_endian = 1'b0;
    logic          read_data_ready = 1'b0;
    logic [0:511]  read_data = '0;
    logic          read_ack;
    logic [3:0]    ch_start;
    logic [31:0]   ch_id;
    logic [15:0]   ch_len;
    logic [463:0]  ch_seq;
    logic [3:0]    ch_done = '0;
    logic [63:0]   ch_score = '0;
    logic          write_data_ready = 1'b0;
    logic [0:511]  write_data;
    logic          write_data_ack;
    logic          flush = 1'b0;
    logic          flush_done;
    logic          idle;
    logic [15:0]   drop_cnt;
    logic [15:0]   clamp_cnt;

    int nvec = 0;
    int nerr = 0;
    logic [0:511] exp_line;
    logic [15:0]  seq_word;

    sw_multi_dispatch #(
        .NUM_CH  (4),
        .LEN_W   (16),
        .RES_W   (16),
        .MAX_LEN (232),
        .ENTRIES (8)
    ) dut (
        .ha_pclock        (ha_pclock),
        .reset            (reset),
        .little_endian    (little_endian),
        .read_data_ready  (read_data_ready),
        .read_data        (read_data),
        .read_ack         (read_ack),
        .ch_start         (ch_start),
        .ch_id            (ch_id),
        .ch_len           (ch_len),
        .ch_seq           (ch_seq),
        .ch_done          (ch_done),
        .ch_score         (ch_score),
        .write_data_ready (write_data_ready),
        .write_data       (write_data),
        .write_data_ack   (write_data_ack),
        .flush            (flush),
        .flush_done       (flush_done),
        .idle             (idle),
        .drop_cnt         (drop_cnt),
        .clamp_cnt        (clamp_cnt)
    );

    always #5 ha_pclock = ~ha_pclock;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ha_pclock);
        #1;
    endtask

    task automatic put_line(input logic [31:0] id, input logic [15:0] len);
        logic [15:0] w;
        w = id[15:0];
        read_data         = '0;
        read_data[0:31]   = id;
        read_data[32:47]  = len;
        read_data[48:511] = {29{w}};
        read_data_ready   = 1'b1;
    endtask

    function automatic logic [63:0] ent(input int id, input int score, input int ch);
        return {id[31:0], score[15:0], ch[7:0], 8'h01};
    endfunction

    initial begin
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_idle", 512'(idle), 512'(1));
        chk("rst_read_ack", 512'(read_ack), 512'(0));
        chk("rst_ch_start", 512'(ch_start), 512'(0));
        chk("rst_write_data", 512'(write_data), 512'(0));
        chk("rst_write_ack", 512'(write_data_ack), 512'(0));
        chk("rst_flush_done", 512'(flush_done), 512'(0));
        chk("rst_drop", 512'(drop_cnt), 512'(0));
        chk("rst_clamp", 512'(clamp_cnt), 512'(0));

        // Four back-to-back lines land on ch0..ch3 in order
        for (int k = 0; k < 4; k++) begin
            put_line(32'(k + 1), 16'd10);
            #1;
            chk("b2b_read_ack", 512'(read_ack), 512'(1));
            step();
            seq_word = 16'(k + 1);
            chk("b2b_ch_start", 512'(ch_start), 512'(4'b0001 << k));
            chk("b2b_ch_id", 512'(ch_id), 512'(k + 1));
            chk("b2b_ch_len", 512'(ch_len), 512'(10));
            chk("b2b_ch_seq", 512'(ch_seq), 512'({29{seq_word}}));
        end
        put_line(32'd5, 16'd10);
        #1;
        chk("fifth_held", 512'(read_ack), 512'(0));
        step();
        chk("fifth_no_start", 512'(ch_start), 512'(0));

        // All four channels finish together
        ch_done  = 4'hf;
        ch_score = {16'd103, 16'd102, 16'd101, 16'd100};
        step();
        ch_done = '0;
        chk("done_still_busy", 512'(read_ack), 512'(0));
        step();
        chk("ch0_freed", 512'(read_ack), 512'(1));
        step();
        read_data_ready = 1'b0;
        chk("fifth_start", 512'(ch_start), 512'(4'b0001));
        chk("fifth_id", 512'(ch_id), 512'(5));
        step();
        step();
        exp_line = '0;
        for (int i = 0; i < 4; i++) begin
            exp_line[64*i +: 64] = ent(i + 1, 100 + i, i);
        end
        chk("four_packed", 512'(write_data), 512'(exp_line));
        chk("four_no_ack", 512'(write_data_ack), 512'(0));

        // Fill the buffer to eight entries with write back-pressure
        for (int k = 1; k < 4; k++) begin
            put_line(32'(5 + k), 16'd10);
            #1;
            chk("fill_read_ack", 512'(read_ack), 512'(1));
            step();
            chk("fill_ch_start", 512'(ch_start), 512'(4'b0001 << k));
            chk("fill_ch_id", 512'(ch_id), 512'(5 + k));
        end
        read_data_ready = 1'b0;
        ch_done  = 4'hf;
        ch_score = {16'd203, 16'd202, 16'd201, 16'd200};
        step();
        ch_done = '0;
        repeat (4) step();
        for (int i = 0; i < 4; i++) begin
            exp_line[64*(i + 4) +: 64] = ent(i + 5, 200 + i, i);
        end
        chk("eight_packed", 512'(write_data), 512'(exp_line));
        chk("full_no_ready", 512'(write_data_ack), 512'(0));

        put_line(32'd9, 16'd10);
        #1;
        chk("id9_read_ack", 512'(read_ack), 512'(1));
        step();
        read_data_ready = 1'b0;
        chk("id9_start", 512'(ch_start), 512'(4'b0001));
        ch_done  = 4'b0001;
        ch_score = 64'd300;
        step();
        ch_done = '0;
        step();
        step();
        chk("stall_unchanged", 512'(write_data), 512'(exp_line));
        chk("stall_not_idle", 512'(idle), 512'(0));
        write_data_ready = 1'b1;
        #1;
        chk("full_ack", 512'(write_data_ack), 512'(1));
        step();
        write_data_ready = 1'b0;
        #1;
        chk("ack_clears", 512'(write_data), 512'(0));
        chk("ack_single", 512'(write_data_ack), 512'(0));
        step();
        exp_line = '0;
        exp_line[0:63] = ent(9, 300, 0);
        chk("stalled_packed", 512'(write_data), 512'(exp_line));

        // Zero-length drop and over-length clamp
        put_line(32'd10, 16'd0);
        #1;
        chk("drop_read_ack", 512'(read_ack), 512'(1));
        step();
        chk("drop_no_start", 512'(ch_start), 512'(0));
        chk("drop_cnt", 512'(drop_cnt), 512'(1));
        put_line(32'd11, 16'd300);
        step();
        read_data_ready = 1'b0;
        chk("clamp_start", 512'(ch_start), 512'(4'b0010));
        chk("clamp_len", 512'(ch_len), 512'(232));
        chk("clamp_cnt", 512'(clamp_cnt), 512'(1));

        // Little-endian length and score fields
        little_endian = 1'b1;
        put_line(32'd12, 16'h0a00);
        step();
        read_data_ready = 1'b0;
        chk("le_start", 512'(ch_start), 512'(4'b0100));
        chk("le_len", 512'(ch_len), 512'(10));
        ch_done  = 4'b0110;
        ch_score = {16'h0000, 16'h0102, 16'h0304, 16'h0000};
        step();
        ch_done = '0;
        step();
        step();
        little_endian = 1'b0;
        exp_line[64 +: 64]  = ent(11, 16'h0403, 1);
        exp_line[128 +: 64] = ent(12, 16'h0201, 2);
        chk("le_scores", 512'(write_data), 512'(exp_line));

        // Flush with three entries buffered
        flush = 1'b1;
        #1;
        chk("flush_no_ready", 512'(write_data_ack), 512'(0));
        step();
        flush = 1'b0;
        put_line(32'd13, 16'd10);
        #1;
        chk("flush_blocks_read", 512'(read_ack), 512'(0));
        chk("flush_line", 512'(write_data), 512'(exp_line));
        write_data_ready = 1'b1;
        #1;
        chk("flush_ack", 512'(write_data_ack), 512'(1));
        step();
        write_data_ready = 1'b0;
        read_data_ready  = 1'b0;
        chk("flush_done_pulse", 512'(flush_done), 512'(1));
        chk("flush_cleared", 512'(write_data), 512'(0));
        step();
        chk("flush_done_single", 512'(flush_done), 512'(0));
        chk("flush_idle", 512'(idle), 512'(1));

        // Flush with an empty buffer
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("empty_flush_done", 512'(flush_done), 512'(1));
        step();
        chk("empty_flush_single", 512'(flush_done), 512'(0));
        put_line(32'd14, 16'd10);
        #1;
        chk("post_flush_read", 512'(read_ack), 512'(1));
        read_data_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/sw_multi_dispatch.md
Name: sw_multi_dispatch

Overview:
- Parametrised successor to the single-aligner AFU data path.
- Accepts 512-bit DMA read lines, each carrying {query ID, length, packed sequence}, and dispatches them round-robin to NUM_CH scoring channels.
- Collects per-channel scores and packs them into 512-bit DMA write lines.
- Sits between the dma read/write data ports and the array of scoring modules. Handles endianess, back-pressure and the end-of-job flush.

Parameters:
- NUM_CH, 4, number of scoring channels (1..16).
- LEN_W, 16, length field width in bits.
- RES_W, 16, score width in bits.
- MAX_LEN, 232, maximum bases per line (464 sequence bits at 2 bits per base).
- ENTRIES, 8, result entries per write line; each entry is 64 bits.

Ports:
- ha_pclock  in  1  clock
- reset  in  1  synchronous, active-high
- little_endian  in  1  from job; byte-swap the length and score fields when set
- read_data_ready  in  1  DMA read line valid
- read_data  in  [0:511]  bits 0:31 ID, 32:47 length, 48:511 sequence
- read_ack  out  1  line consumed this cycle
- ch_start  out  NUM_CH  one-cycle start pulse per channel
- ch_id  out  32  ID of the dispatched query
- ch_len  out  LEN_W  length of the dispatched query
- ch_seq  out  464  sequence of the dispatched query
- ch_done  in  NUM_CH  one-cycle result pulse per channel
- ch_score  in  NUM_CH*RES_W  flattened scores; channel k uses slice k
- write_data_ready  in  1  DMA can take a write line
- write_data  out  [0:511]  packed result line
- write_data_ack  out  1  write line consumed this cycle
- flush  in  1  end-of-job pulse
- flush_done  out  1  one-cycle pulse
- idle  out  1  no busy or pending channel and buffer empty
- drop_cnt  out  16  zero-length lines dropped, saturating
- clamp_cnt  out  16  over-length lines clamped, saturating

Behaviour:
- Reset values: all outputs 0 except idle=1. All channels free, round-robin pointers 0, buffer count 0, ID register cleared.
- Dispatch:
  - read_ack = read_data_ready & any_free & !flushing. This is combinational; the line is captured on the same edge.
  - Length is endian-corrected first.
  - Length == 0: line is consumed, drop_cnt increments, no channel start.
  - Length > MAX_LEN: length is clamped to MAX_LEN and clamp_cnt increments.
  - Otherwise the free channel chosen round-robin from the pointer gets ch_start[k]=1 in cycle T+1, with ch_id/ch_len/ch_seq held valid that cycle. The channel is marked busy from T+1. The pointer then moves to k+1 mod NUM_CH.
  - At most one dispatch per cycle.
- Collection:
  - ch_done[k] latches the score into per-channel holding register k and sets pend[k]; the channel stays busy until its entry is packed.
  - Any number of channels may finish in the same cycle; none are lost.
  - A round-robin arbiter moves one pending entry per cycle into the buffer, unless the buffer is full.
  - The packed entry clears pend[k] and busy[k]; channel k is free the next cycle.
  - Entry layout, MSB first: ID(32), score(16, endian-corrected), channel index(8), flag 8'h01.
  - Entry i occupies write_data bits [64i : 64i+63].
- Write:
  - When the count reaches ENTRIES the line is full: write_data_ack = write_data_ready & full.
  - On the ack, the count returns to 0 and the entries are zeroed on the same edge.
  - Packing stalls while the buffer is full.
- Flush:
  - flush sets flushing, which blocks read_ack.
  - When no channel is busy or pending:
    - If count > 0, the line is forced full. Unused entries are 0, so their flag is 0.
    - After it is acked, flush_done pulses and flushing clears.
    - If count == 0, flush_done pulses the next cycle.
  - A flush while already flushing is ignored.
- Reset mid-operation: everything returns to reset values the next edge. In-flight results are discarded.

Decomposition:
- Package sw_dispatch_pkg:
  - line field offsets (ID_LSB/MSB, LEN_LSB/MSB, SEQ_LSB/MSB)
  - entry layout constants
  - ENTRY_FLAG_VALID = 8'h01
  - entry typedef
- Reuse the existing endian_swap for the length (BYTES=2) and score (BYTES=2) fields.
- One natural sub-module: rr_arbiter (parametrised width, pointer advances past the grant). It is instantiated twice: free-channel selection and pending-result selection.

Test Plan:
- NUM_CH=4, all free, 4 back-to-back lines with IDs 1..4, length 10 -> ch_start pulses on ch0..3 in consecutive cycles; the fifth line is held (read_ack=0) until a ch_done.
- All 4 channels assert ch_done in the same cycle with scores 100..103 -> 4 entries packed over 4 cycles in order ch0..3; no score lost.
- 8 results with write_data_ready=0 -> buffer full, packing stalls, channels stay busy. Then ready=1 -> single-cycle write_data_ack, the line holds IDs in order, count returns to 0.
- Line with length 0 -> read_ack=1, no ch_start, drop_cnt=1. Line with length 300 -> ch_len=232, clamp_cnt=1.
- little_endian=1 with length bytes 0x0A00 -> ch_len=10; score 0x0102 -> entry score field 0x0201.
- 3 results, then flush -> read_ack blocked; line written with entries 3..7 all zero; flush_done one cycle after the ack. A flush with an empty buffer -> flush_done the next cycle.
